cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. Read hits return data in the same cycle. Read misses and all writes are forwarded to the SRAM controller, and the pipeline is stalled through `ready` until the SRAM side completes. The SRAM-side ports connect one-to-one to the SRAM controller's CPU-side request/ready interface.

---
 rtl/cache_controller.sv | 166 ++++++++++++++++
 tb/tb_cache_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache in front of the SRAM controller.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module cache_controller #(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         data;
  } line_t;

  state_e                 state_q;
  logic                   first_q;
  logic [SETS-1:0][1:0]   valid_q;
  logic [SETS-1:0]        lru_q;
  line_t [1:0]            line_q [SETS];

  logic [SET_BITS-1:0] idx_in, idx_q;
  logic [TAG_BITS-1:0] tag_in, tag_q;
  logic                hit0, hit1, hit, hit_way, fill_way, done;
  logic [31:0]         hit_data;

  assign idx_in = address[SET_BITS+1:2];
  assign tag_in = address[SET_BITS+TAG_BITS+1:SET_BITS+2];
  assign idx_q  = sram_address[SET_BITS+1:2];
  assign tag_q  = sram_address[SET_BITS+TAG_BITS+1:SET_BITS+2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[1:0], sram_address[1:0],
                              address[31:SET_BITS+TAG_BITS+2],
                              sram_address[31:SET_BITS+TAG_BITS+2]};

  assign hit0     = valid_q[idx_in][0] && (line_q[idx_in][0].tag == tag_in);
  assign hit1     = valid_q[idx_in][1] && (line_q[idx_in][1].tag == tag_in);
  assign hit      = hit0 | hit1;
  assign hit_way  = !hit0;
  assign hit_data = hit0 ? line_q[idx_in][0].data : line_q[idx_in][1].data;

  // First cycle in RMISS/WRITE ignores sram_ready (controller reports ready while still idle).
  assign done     = !first_q && sram_ready;
  assign fill_way = !valid_q[idx_q][0] ? 1'b0 :
                    !valid_q[idx_q][1] ? 1'b1 : lru_q[idx_q];

  always_comb begin
    ready = 1'b1;
    rdata = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (wr_en) ready = 1'b0;
          else if (rd_en) begin
            if (hit) rdata = hit_data;
            else     ready = 1'b0;
          end
        end
        RMISS: begin
          ready = done;
          if (done) rdata = sram_rdata;
        end
        WRITE:   ready = done;
        default: ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      first_q      <= 1'b0;
      valid_q      <= '0;
      lru_q        <= '0;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            sram_address <= address;
            sram_wdata   <= wdata;
            sram_wr_en   <= 1'b1;
            first_q      <= 1'b1;
            state_q      <= WRITE;
            if (hit) lru_q[idx_in] <= ~hit_way;
          end else if (rd_en) begin
            if (hit) lru_q[idx_in] <= ~hit_way;
            else begin
              sram_address <= address;
              sram_rd_en   <= 1'b1;
              first_q      <= 1'b1;
              state_q      <= RMISS;
            end
          end
        end
        RMISS: begin
          if (done) begin
            sram_rd_en                <= 1'b0;
            state_q                   <= IDLE;
            valid_q[idx_q][fill_way]  <= 1'b1;
            lru_q[idx_q]              <= ~fill_way;
          end
        end
        WRITE: begin
          if (done) begin
            sram_wr_en <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && wr_en && hit)
      line_q[idx_in][hit_way].data <= wdata;
    if (state_q == RMISS && done) begin
      line_q[idx_q][fill_way].tag  <= tag_q;
      line_q[idx_q][fill_way].data <= sram_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic rd_req;
  assign rd_req = (state_q == IDLE) && rd_en && !wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rd_req) begin
      if (hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus queues expectations, a negedge monitor
// checks each completed request against them; a small SRAM controller model answers misses/writes.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_wr;
    bit          hit;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // SRAM controller model: ready while idle, busy for lat cycles, one ready cycle on completion.
  int          lat = 2;
  logic [1:0]  mst;
  int          cnt;
  logic [31:0] smem [8];
  logic        mem_loaded = 1'b0;

  assign sram_ready = (mst != 2'd1);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst        <= 2'd0;
      cnt        <= 0;
      sram_rdata <= '0;
    end else begin
      case (mst)
        2'd0: if (sram_rd_en || sram_wr_en) begin
          mst        <= 2'd1;
          cnt        <= lat - 1;
          sram_rdata <= smem[sram_address[10:8]];
        end
        2'd1: if (cnt == 0) mst <= 2'd2; else cnt <= cnt - 1;
        default: mst <= 2'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem_loaded <= 1'b1;
      smem[0] <= '0; smem[1] <= '0; smem[2] <= '0; smem[3] <= '0;
      smem[4] <= 32'hDEADBEEF;
      smem[5] <= 32'h55550500;
      smem[6] <= 32'h66660600;
      smem[7] <= 32'h77770700;
    end else if (rst && mst == 2'd2 && sram_wr_en) begin
      smem[sram_address[10:8]] <= sram_wdata;
    end
  end

  // Monitor
  int stall_cnt = 0;
  always @(negedge clk) begin
    if (sram_rd_en && sram_wr_en) begin
      n_tests++; n_fail++;
      $display("FAIL both_sram_req: rd=%b wr=%b want not both 1", sram_rd_en, sram_wr_en);
    end
    if (!rst) stall_cnt = 0;
    else if (rd_en || wr_en) begin
      if (!ready) stall_cnt++;
      else if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_completion: addr %h with empty scoreboard", address);
        stall_cnt = 0;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall_cycles", stall_cnt, e.stall);
        if (e.is_wr) begin
          chk("wr_sram_wr_en", {31'd0, sram_wr_en}, 32'd1);
          chk("wr_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
          chk("wr_sram_address", sram_address, e.addr);
          chk("wr_sram_wdata", sram_wdata, e.data);
        end else begin
          chk("rd_rdata", rdata, e.data);
          chk("rd_sram_rd_en", {31'd0, sram_rd_en}, e.hit ? 32'd0 : 32'd1);
          chk("rd_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
          if (!e.hit) chk("rd_sram_address", sram_address, e.addr);
        end
        stall_cnt = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request completes.
  task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                    input int l, input bit exp_hit, input logic [31:0] exp_data);
    exp_t e;
    bit   ok;
    e.is_wr = w;
    e.hit   = exp_hit;
    e.addr  = a;
    e.data  = w ? d : exp_data;
    e.stall = exp_hit ? 0 : 2 + l;
    lat     = l;
    exp_q.push_back(e);
    rd_en = r; wr_en = w; address = a; wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: addr %h never completed, want ready=1 within 60 cycles", a);
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("reset_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
    chk("reset_sram_address", sram_address, 32'd0);
    chk("reset_sram_wdata", sram_wdata, 32'd0);
    @(posedge clk); #1;

    op(1, 0, 32'h400, 0, 2, 0, 32'hDEADBEEF);            // cold miss -> way0
    op(1, 0, 32'h400, 0, 2, 1, 32'hDEADBEEF);            // hit
    op(1, 0, 32'h500, 0, 1, 0, 32'h55550500);            // miss -> way1
    op(1, 0, 32'h600, 0, 3, 0, 32'h66660600);            // evicts 0x400
    op(1, 0, 32'h500, 0, 2, 1, 32'h55550500);            // hit
    op(1, 0, 32'h400, 0, 2, 0, 32'hDEADBEEF);            // miss, evicts 0x600
    op(0, 1, 32'h500, 32'h12345678, 2, 0, 0);            // write hit
    op(1, 0, 32'h500, 0, 2, 1, 32'h12345678);            // hit returns new data
    op(0, 1, 32'h700, 32'hA5A5A5A5, 1, 0, 0);            // write miss, no allocate
    op(1, 0, 32'h700, 0, 2, 0, 32'hA5A5A5A5);            // miss fetches written data, evicts 0x400
    op(1, 1, 32'h400, 32'h0BADF00D, 2, 0, 0);            // write has priority over read
    op(1, 0, 32'h400, 0, 4, 0, 32'h0BADF00D);            // miss, evicts 0x500
    op(1, 0, 32'h700, 0, 2, 1, 32'hA5A5A5A5);            // hit

    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_rdata", rdata, 32'd0);
`ifdef CACHE_STATS_EN
    chk("hit_count", {16'd0, hit_count}, 32'd4);
    chk("miss_count", {16'd0, miss_count}, 32'd6);
`endif

    // Reset in the middle of a read miss
    @(posedge clk); #1;
    lat = 4;
    rd_en = 1'b1; address = 32'h500;
    repeat (3) @(negedge clk);
    chk("rmiss_ready", {31'd0, ready}, 32'd0);
    chk("rmiss_sram_rd_en", {31'd0, sram_rd_en}, 32'd1);
    #1;
    rst = 1'b0; rd_en = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
`ifdef CACHE_STATS_EN
    chk("midrst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("midrst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    op(1, 0, 32'h400, 0, 2, 0, 32'h0BADF00D);            // invalidated by reset -> miss

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
